dimming_frame_sched: RTL and testbench

Ping-pong frame scheduler between the block-mean extractor and the backlight LED driver. It collects the per-block mean stream (40 blocks per burst, 20 bursts per frame) into one bank of a two-bank buffer. At each frame boundary it swaps banks and replays the completed frame, in block order, to the downstream driver over a valid/ready stream. It decouples the video-timed producer from a back-pressured consumer and discards incomplete or unconsumable frames.

---
 rtl/dimming_pkg.sv | 19 +
 rtl/dimming_bank_ram.sv | 28 ++
 rtl/dimming_frame_sched.sv | 150 +++++++++++++++
 tb/tb_dimming_frame_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dimming_pkg.sv
// Shared geometry and read-FSM encoding for the dimming frame scheduler.
package dimming_pkg;

  localparam int BLOCKS_X   = 40;
  localparam int BLOCKS_Y   = 20;
  localparam int NUM_BLOCKS = BLOCKS_X * BLOCKS_Y;
  localparam int IDX_W      = 10;
  localparam int DW         = 8;

  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SEND  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dimming_bank_ram.sv
// Two-bank block-mean buffer: one write port, one registered read port.
module dimming_bank_ram
  import dimming_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0] mem [2][NUM_BLOCKS];

  // No reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_bank][rd_idx];
    end
  end

endmodule

// File: rtl/dimming_frame_sched.sv
// Ping-pong frame scheduler: fills one bank from the block-mean stream and
// replays the completed bank to the LED driver over valid/ready.
//
// state | meaning
// IDLE  | no replay in progress, waiting for a complete frame at vs rise
// PRIME | RAM read of rd_bank[rd_idx] issued, out_valid low
// SEND  | word presented, held until out_ready
module dimming_frame_sched
  import dimming_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             vs,
  input  logic             mean_valid,
  input  logic [DW-1:0]    mean_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_sof,
  output logic             out_eof,
  output logic             frame_drop,
  output logic             busy
);

  rd_state_e        state_q, state_d;
  logic             vs_prev_q;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             frame_drop_q, frame_drop_d;

  logic             vs_rise, wr_full, swap;
  logic             ram_we, ram_wr_bank, ram_rd_en;
  logic [IDX_W-1:0] ram_wr_idx;
  logic [DW-1:0]    ram_rd_data;

  assign vs_rise = vs & ~vs_prev_q;
  assign wr_full = (wr_idx_q == IDX_FULL);
  assign swap    = vs_rise && wr_full && (state_q == ST_IDLE);

  // Completeness uses the pre-edge count; a coincident sample opens the new frame.
  always_comb begin
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    frame_drop_d = 1'b0;
    ram_we       = 1'b0;
    ram_wr_bank  = wr_bank_q;
    ram_wr_idx   = wr_idx_q;
    if (vs_rise) begin
      if (swap) begin
        wr_bank_d = ~wr_bank_q;
        rd_bank_d = wr_bank_q;
      end else begin
        frame_drop_d = 1'b1;
      end
      ram_wr_bank = wr_bank_d;
      ram_wr_idx  = '0;
      ram_we      = mean_valid;
      wr_idx_d    = mean_valid ? IDX_W'(1) : '0;
    end else if (mean_valid && !wr_full) begin
      ram_we   = 1'b1;
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      vs_prev_q    <= 1'b0;
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs;
      wr_idx_q     <= wr_idx_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (swap) begin
          state_d  = ST_PRIME;
          rd_idx_d = '0;
        end
      end
      ST_PRIME: state_d = ST_SEND;
      ST_SEND: begin
        if (out_ready) begin
          if (rd_idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_PRIME;
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM output only reloads in PRIME, so data is held for the whole SEND stall.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    ram_rd_en = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_PRIME: ram_rd_en = 1'b1;
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = ram_rd_data;
        out_index = rd_idx_q;
        out_sof   = (rd_idx_q == '0);
        out_eof   = (rd_idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

  assign frame_drop = frame_drop_q;

  dimming_bank_ram u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_bank (ram_wr_bank),
    .wr_idx  (ram_wr_idx),
    .wr_data (mean_data),
    .rd_en   (ram_rd_en),
    .rd_bank (rd_bank_q),
    .rd_idx  (rd_idx_q),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_dimming_frame_sched.sv
// Directed bench for dimming_frame_sched: frame table plus hand-written corner sequences.
module tb_dimming_frame_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       vs = 1'b0;
  logic       mean_valid = 1'b0;
  logic [7:0] mean_data = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [9:0] out_index;
  logic       out_sof, out_eof, frame_drop, busy;

  int n_checks = 0;
  int n_err    = 0;

  dimming_frame_sched dut (
    .clk        (clk),
    .rstn       (rstn),
    .vs         (vs),
    .mean_valid (mean_valid),
    .mean_data  (mean_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_drop (frame_drop),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_samp;
    int base;
    bit rnd;
    bit exp_drop;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_frame(input int start, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mean_valid = 1'b1;
      mean_data  = 8'((start + i + base) & 255);
    end
    @(negedge clk);
    mean_valid = 1'b0;
  endtask

  // Returns at the negedge of cycle N+1, where frame_drop must be visible.
  task automatic vs_pulse(input bit mv, input logic [7:0] md, input bit exp_drop);
    @(negedge clk);
    vs = 1'b1;
    mean_valid = mv;
    mean_data  = md;
    @(negedge clk);
    vs = 1'b0;
    mean_valid = 1'b0;
    check("frame_drop_n1", 32'(frame_drop), 32'(exp_drop));
  endtask

  task automatic run_replay(input int base, input bit rnd, input bit chk_cyc);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] hd = '0;
    logic [9:0] hi = '0;
    logic [19:0] exp_w;
    while (busy && cyc < 6000) begin
      cyc++;
      if (stalled) begin
        check("stall_hold", {out_valid, out_data, out_index}, {1'b1, hd, hi});
      end
      if (out_valid) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          exp_w = {8'((k + base) & 255), 10'(k), (k == 0), (k == 799)};
          check("replay_word", {out_data, out_index, out_sof, out_eof}, exp_w);
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = out_data;
          hi = out_index;
        end
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("replay_words", 32'(k), 32'd800);
    check("replay_busy_done", 32'(busy), 32'd0);
    if (chk_cyc) check("replay_cycles", 32'(cyc), 32'd1600);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   cyc;
    vecs[0] = '{800, 0,  1'b0, 1'b0};
    vecs[1] = '{800, 17, 1'b1, 1'b0};
    vecs[2] = '{799, 5,  1'b0, 1'b1};
    vecs[3] = '{805, 99, 1'b0, 1'b0};
    vecs[4] = '{0,   0,  1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_out_index",  32'(out_index),  32'd0);
    check("rst_sof_eof",    {out_sof, out_eof}, 32'd0);
    check("rst_frame_drop", 32'(frame_drop), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      write_frame(0, vecs[v].n_samp, vecs[v].base);
      vs_pulse(1'b0, 8'd0, vecs[v].exp_drop);
      if (vecs[v].exp_drop) begin
        check("drop_busy", 32'(busy), 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("drop_no_valid", {out_valid, frame_drop}, 32'd0);
        end
      end else begin
        check("swap_prime", {busy, out_valid}, 32'b10);
        run_replay(vecs[v].base, vecs[v].rnd, !vecs[v].rnd);
      end
    end

    // Frame B completes while A is stalled: B dropped, A intact, C replays.
    write_frame(0, 800, 50);
    vs_pulse(1'b0, 8'd0, 1'b0);
    out_ready = 1'b0;
    write_frame(0, 800, 150);
    vs_pulse(1'b0, 8'd0, 1'b1);
    check("a_still_stalled", {out_valid, out_index}, {1'b1, 10'd0});
    run_replay(50, 1'b0, 1'b0);
    write_frame(0, 800, 200);
    vs_pulse(1'b0, 8'd0, 1'b0);
    run_replay(200, 1'b0, 1'b1);

    // Sample coincident with the vs rise lands at index 0 of the new bank.
    write_frame(0, 800, 3);
    vs_pulse(1'b1, 8'd100, 1'b0);
    run_replay(3, 1'b0, 1'b1);
    write_frame(1, 799, 100);
    vs_pulse(1'b0, 8'd0, 1'b0);
    run_replay(100, 1'b0, 1'b1);

    // Reset at word 300 of a replay.
    write_frame(0, 800, 7);
    vs_pulse(1'b0, 8'd0, 1'b0);
    cyc = 0;
    while (!(out_valid && out_index == 10'd300) && cyc < 2000) begin
      out_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("reach_word300", {out_valid, out_data, out_index}, {1'b1, 8'd51, 10'd300});
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_index", 32'(out_index), 32'd0);
    check("mid_rst_flags", {out_sof, out_eof, frame_drop, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    write_frame(0, 800, 77);
    vs_pulse(1'b0, 8'd0, 1'b0);
    check("post_rst_prime", {busy, out_valid}, 32'b10);
    run_replay(77, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
